// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: result-select codes, load funct3 codes and the W-stage field bundle.
package pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned CNT_W  = 64;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_LOAD = 2'b01,
    RES_PC4  = 2'b10,
    RES_IMM  = 2'b11
  } result_src_e;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    result_src_e       result_src;
    logic [F3_W-1:0]   funct3;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   read_data;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   imm_ext;
    logic [REG_AW-1:0] rd;
  } wb_fields_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load lane extraction and sign/zero extension with misaligned/illegal-width detection.
module load_extend
  import pipe_pkg::*;
(
  input  logic            is_load,
  input  logic [F3_W-1:0] funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] read_data,
  output logic [XLEN-1:0] load_data_c,
  output logic            misalign_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        bad_c;

  always_comb begin
    byte_sel = read_data[7:0];
    case (addr_lo)
      2'd1:    byte_sel = read_data[15:8];
      2'd2:    byte_sel = read_data[23:16];
      2'd3:    byte_sel = read_data[31:24];
      default: byte_sel = read_data[7:0];
    endcase
    half_sel = addr_lo[1] ? read_data[31:16] : read_data[15:0];
  end

  // Illegal or misaligned accesses yield zero data so the result mux never leaks a partial word.
  always_comb begin
    load_data_c = '0;
    bad_c       = 1'b0;
    case (funct3)
      F3_LB:  load_data_c = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: load_data_c = {24'd0, byte_sel};
      F3_LH: begin
        if (addr_lo[0]) bad_c = 1'b1;
        else            load_data_c = {{16{half_sel[15]}}, half_sel};
      end
      F3_LHU: begin
        if (addr_lo[0]) bad_c = 1'b1;
        else            load_data_c = {16'd0, half_sel};
      end
      F3_LW: begin
        if (addr_lo != 2'b00) bad_c = 1'b1;
        else                  load_data_c = read_data;
      end
      default: bad_c = 1'b1;
    endcase
    misalign_c = is_load & bad_c;
  end

endmodule

// File: rtl/writeback_stage.sv
// M->W pipeline register with result select, load extension and register-file write gating.
// Optional retired-instruction counter InstretW is built only when WB_INSTRET_EN is defined.
module writeback_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic              ValidM,
  input  logic              RegWriteM,
  input  logic [1:0]        ResultSrcM,
  input  logic [F3_W-1:0]   Funct3M,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   ReadDataM,
  input  logic [XLEN-1:0]   PCPlus4M,
  input  logic [XLEN-1:0]   ImmExtM,
  input  logic [REG_AW-1:0] RdM,
  output logic [REG_AW-1:0] RdW,
  output logic [XLEN-1:0]   ResultW,
  output logic              RegWriteW,
  output logic              ValidW,
  output logic              LoadMisalignW
`ifdef WB_INSTRET_EN
  ,
  output logic [CNT_W-1:0]  InstretW
`endif
);

  wb_fields_t      w_q, w_d, m_fields;
  logic [XLEN-1:0] load_data_c;
  logic            misalign_c;
  logic            is_load_c;

  always_comb begin
    m_fields            = '0;
    m_fields.valid      = 1'b1;
    m_fields.reg_write  = RegWriteM;
    m_fields.result_src = result_src_e'(ResultSrcM);
    m_fields.funct3     = Funct3M;
    m_fields.alu_result = ALUResultM;
    m_fields.read_data  = ReadDataM;
    m_fields.pc_plus4   = PCPlus4M;
    m_fields.imm_ext    = ImmExtM;
    m_fields.rd         = RdM;
  end

  // Flush beats stall; an invalid M slot is captured as a full bubble.
  always_comb begin
    w_d = w_q;
    if (FlushW)       w_d = '0;
    else if (!StallW) w_d = ValidM ? m_fields : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) w_q <= '0;
    else     w_q <= w_d;
  end

  assign is_load_c = w_q.valid & (w_q.result_src == RES_LOAD);

  load_extend u_load_extend (
    .is_load     (is_load_c),
    .funct3      (w_q.funct3),
    .addr_lo     (w_q.alu_result[1:0]),
    .read_data   (w_q.read_data),
    .load_data_c (load_data_c),
    .misalign_c  (misalign_c)
  );

  always_comb begin
    ResultW = w_q.alu_result;
    case (w_q.result_src)
      RES_LOAD: ResultW = load_data_c;
      RES_PC4:  ResultW = w_q.pc_plus4;
      RES_IMM:  ResultW = w_q.imm_ext;
      default:  ResultW = w_q.alu_result;
    endcase
  end

  assign RdW           = w_q.rd;
  assign ValidW        = w_q.valid;
  assign LoadMisalignW = misalign_c;
  assign RegWriteW     = w_q.reg_write & w_q.valid & (w_q.rd != '0) & ~misalign_c;

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;

  // Retirement is judged on the instruction currently in W; a flush replaces it only afterwards.
  always_comb begin
    instret_d = instret_q;
    if (w_q.valid && !StallW && !misalign_c) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign InstretW = instret_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors push expected W state, a monitor pops and compares.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        StallW, FlushW, ValidM, RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M, ImmExtM;
  logic [4:0]  RdM;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        RegWriteW, ValidW, LoadMisalignW;
`ifdef WB_INSTRET_EN
  logic [63:0] InstretW;
`endif

  writeback_stage dut (
    .clk           (clk),
    .rst           (rst),
    .StallW        (StallW),
    .FlushW        (FlushW),
    .ValidM        (ValidM),
    .RegWriteM     (RegWriteM),
    .ResultSrcM    (ResultSrcM),
    .Funct3M       (Funct3M),
    .ALUResultM    (ALUResultM),
    .ReadDataM     (ReadDataM),
    .PCPlus4M      (PCPlus4M),
    .ImmExtM       (ImmExtM),
    .RdM           (RdM),
    .RdW           (RdW),
    .ResultW       (ResultW),
    .RegWriteW     (RegWriteW),
    .ValidW        (ValidW),
    .LoadMisalignW (LoadMisalignW)
`ifdef WB_INSTRET_EN
    ,
    .InstretW      (InstretW)
`endif
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] result;
    logic        regw;
    logic        valid;
    logic        mis;
    logic [63:0] instret;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec  = 0;
  int          n_fail = 0;
  int          vec_id = 0;
  logic [63:0] m_instret = '0;
  logic        prev_valid = 1'b0;
  logic        prev_mis   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one M-stage vector at the falling edge and queue the W state expected after the next rising edge.
  task automatic apply(
    input logic rst_i, input logic stall_i, input logic flush_i, input logic valid_i,
    input logic regw_i, input logic [1:0] src_i, input logic [2:0] f3_i,
    input logic [31:0] alu_i, input logic [31:0] rdata_i, input logic [31:0] pc4_i,
    input logic [31:0] imm_i, input logic [4:0] rd_i,
    input logic [4:0] e_rd, input logic [31:0] e_res, input logic e_regw,
    input logic e_valid, input logic e_mis);
    exp_t e;
    @(negedge clk);
    rst = rst_i; StallW = stall_i; FlushW = flush_i; ValidM = valid_i;
    RegWriteM = regw_i; ResultSrcM = src_i; Funct3M = f3_i;
    ALUResultM = alu_i; ReadDataM = rdata_i; PCPlus4M = pc4_i; ImmExtM = imm_i; RdM = rd_i;
    if (rst_i)                                 m_instret = '0;
    else if (prev_valid && !stall_i && !prev_mis) m_instret = m_instret + 64'd1;
    e.rd = e_rd; e.result = e_res; e.regw = e_regw; e.valid = e_valid; e.mis = e_mis;
`ifdef WB_INSTRET_EN
    e.instret = m_instret;
`else
    e.instret = '0;
`endif
    exp_q.push_back(e);
    prev_valid = e_valid;
    prev_mis   = e_mis;
  endtask

  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.rd = RdW; a.result = ResultW; a.regw = RegWriteW; a.valid = ValidW; a.mis = LoadMisalignW;
`ifdef WB_INSTRET_EN
      a.instret = InstretW;
`else
      a.instret = '0;
`endif
      n_vec++;
      if (a != e) begin
        n_fail++;
        $display("FAIL vec%0d: got rd=%0d res=%h regw=%b valid=%b mis=%b instret=%h, expected rd=%0d res=%h regw=%b valid=%b mis=%b instret=%h",
                 vec_id, a.rd, a.result, a.regw, a.valid, a.mis, a.instret,
                 e.rd, e.result, e.regw, e.valid, e.mis, e.instret);
      end
      vec_id++;
    end
  end

  initial begin
    int guard;
    rst = 1'b1; StallW = 1'b0; FlushW = 1'b0; ValidM = 1'b0; RegWriteM = 1'b0;
    ResultSrcM = 2'b00; Funct3M = 3'b000; ALUResultM = '0; ReadDataM = '0;
    PCPlus4M = '0; ImmExtM = '0; RdM = '0;

    // reset state
    apply(1,0,0,1,1,2'b00,3'b000,32'h1111_1111,32'h0,32'h0,32'h0,5'd9,  5'd0,32'h0,0,0,0);
    // LB byte 3, negative
    apply(0,0,0,1,1,2'b01,3'b000,32'h0000_1003,32'h80FF_0000,32'h0,32'h0,5'd5,  5'd5,32'hFFFF_FF80,1,1,0);
    // LW at addr ...02 misaligned
    apply(0,0,0,1,1,2'b01,3'b010,32'h0000_1002,32'hDEAD_BEEF,32'h0,32'h0,5'd6,  5'd6,32'h0,0,1,1);
    // rd=0 ALU write suppressed
    apply(0,0,0,1,1,2'b00,3'b000,32'h0000_1234,32'h0,32'h0,32'h0,5'd0,  5'd0,32'h0000_1234,0,1,0);
    // LH upper half, sign-extended
    apply(0,0,0,1,1,2'b01,3'b001,32'h0000_0002,32'h8001_7FFF,32'h0,32'h0,5'd7,  5'd7,32'hFFFF_8001,1,1,0);
    // LBU byte 1
    apply(0,0,0,1,1,2'b01,3'b100,32'h0000_0001,32'h1234_9A78,32'h0,32'h0,5'd8,  5'd8,32'h0000_009A,1,1,0);
    // LHU lower half
    apply(0,0,0,1,1,2'b01,3'b101,32'h0000_0000,32'hABCD_8765,32'h0,32'h0,5'd9,  5'd9,32'h0000_8765,1,1,0);
    // LH odd address misaligned
    apply(0,0,0,1,1,2'b01,3'b001,32'h0000_0003,32'hABCD_8765,32'h0,32'h0,5'd9,  5'd9,32'h0,0,1,1);
    // PC+4 and immediate selects
    apply(0,0,0,1,1,2'b10,3'b000,32'h0000_0040,32'h0,32'h0000_0104,32'h0,5'd1,  5'd1,32'h0000_0104,1,1,0);
    apply(0,0,0,1,1,2'b11,3'b000,32'h0000_0040,32'h0,32'h0,32'hFFFF_F800,5'd2,  5'd2,32'hFFFF_F800,1,1,0);
    // illegal funct3 011 on load
    apply(0,0,0,1,1,2'b01,3'b011,32'h0000_0000,32'h5555_5555,32'h0,32'h0,5'd3,  5'd3,32'h0,0,1,1);
    // aligned LW
    apply(0,0,0,1,1,2'b01,3'b010,32'h0000_0004,32'hDEAD_BEEF,32'h0,32'h0,5'd15, 5'd15,32'hDEAD_BEEF,1,1,0);
    // ValidM=0 is a bubble regardless of write/select
    apply(0,0,0,0,1,2'b01,3'b011,32'h0000_0055,32'h0,32'h0,32'h0,5'd4,  5'd0,32'h0,0,0,0);
    // stall for three cycles with new M data
    apply(0,0,0,1,1,2'b00,3'b000,32'h0000_AAAA,32'h0,32'h0,32'h0,5'd10, 5'd10,32'h0000_AAAA,1,1,0);
    for (int i = 0; i < 3; i++)
      apply(0,1,0,1,1,2'b00,3'b000,32'h0000_BBBB,32'h0,32'h0,32'h0,5'd11, 5'd10,32'h0000_AAAA,1,1,0);
    apply(0,0,0,1,1,2'b00,3'b000,32'h0000_BBBB,32'h0,32'h0,32'h0,5'd11, 5'd11,32'h0000_BBBB,1,1,0);
    // flush and stall together -> bubble
    apply(0,1,1,1,1,2'b00,3'b000,32'h0000_CCCC,32'h0,32'h0,32'h0,5'd12, 5'd0,32'h0,0,0,0);
    apply(0,0,0,1,1,2'b00,3'b000,32'h0000_DDDD,32'h0,32'h0,32'h0,5'd13, 5'd13,32'h0000_DDDD,1,1,0);
    // flush alone
    apply(0,0,1,1,1,2'b11,3'b000,32'h0,32'h0,32'h0,32'h0000_0777,5'd14, 5'd0,32'h0,0,0,0);
    apply(0,0,0,1,1,2'b11,3'b000,32'h0,32'h0,32'h0,32'h0000_0777,5'd14, 5'd14,32'h0000_0777,1,1,0);
    // reset asserted mid-stall with a valid instruction in W
    apply(0,1,0,1,1,2'b00,3'b000,32'h0000_EEEE,32'h0,32'h0,32'h0,5'd16, 5'd14,32'h0000_0777,1,1,0);
    apply(1,1,0,1,1,2'b00,3'b000,32'h0000_EEEE,32'h0,32'h0,32'h0,5'd16, 5'd0,32'h0,0,0,0);
    apply(0,0,0,1,1,2'b00,3'b000,32'h0000_0001,32'h0,32'h0,32'h0,5'd17, 5'd17,32'h0000_0001,1,1,0);
`ifdef WB_INSTRET_EN
    // preset counter to all-ones so the next retire wraps to zero
    @(posedge clk);
    #2;
    dut.instret_q = '1;
    m_instret     = '1;
`endif
    apply(0,0,0,0,0,2'b00,3'b000,32'h0,32'h0,32'h0,32'h0,5'd0,  5'd0,32'h0,0,0,0);

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
